// File: rtl/ex.sv
// ---------------------------------------------------------------------------
// Module  : ex
// Brief   : Execute stage - logic/shift/arith ALU plus a 32-cycle restoring
//           divider that stalls the pipeline while it runs.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_ZERO = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        w_is_div, w_signed;
  logic [31:0] w_abs1, w_abs2;
  logic [32:0] w_shift, w_sub;
  logic [31:0] w_logic, w_shres, w_arith, w_sel;
  logic [31:0] w_quot, w_rem;

  assign w_is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign w_signed = (aluop_i == OP_DIV);
  assign w_abs1   = (w_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign w_abs2   = (w_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  // Restoring step: bring the next dividend bit into the partial remainder
  // and keep the difference only if the trial subtraction did not borrow.
  assign w_shift = {rem_q, dvd_q[31]};
  assign w_sub   = w_shift - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FREE;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_FREE: begin
        if (w_is_div) begin
          cnt_d = 5'd0;
          rem_d = 32'd0;
          if (reg2_i == 32'd0) begin
            state_d = S_ZERO;
            dvd_d   = 32'd0;
            dvs_d   = 32'd0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = S_ON;
            dvd_d   = w_abs1;
            dvs_d   = w_abs2;
            qneg_d  = w_signed && (reg1_i[31] ^ reg2_i[31]);
            rneg_d  = w_signed && reg1_i[31];
          end
        end
      end
      S_ZERO: state_d = S_END;
      S_ON: begin
        if (!w_sub[32]) begin
          rem_d = w_sub[31:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          rem_d = w_shift[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_END;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_comb begin
    w_quot     = qneg_q ? (~dvd_q + 32'd1) : dvd_q;
    w_rem      = rneg_q ? (~rem_q + 32'd1) : rem_q;
    whilo_o    = rst && (state_q == S_END);
    lo_o       = whilo_o ? w_quot : 32'd0;
    hi_o       = whilo_o ? w_rem  : 32'd0;
    stallreq_o = rst && ((state_q == S_ZERO) || (state_q == S_ON) ||
                         ((state_q == S_FREE) && w_is_div));
  end

  always_comb begin
    w_logic = 32'd0;
    w_shres = 32'd0;
    w_arith = 32'd0;
    case (aluop_i)
      OP_AND:  w_logic = reg1_i & reg2_i;
      OP_OR:   w_logic = reg1_i | reg2_i;
      OP_XOR:  w_logic = reg1_i ^ reg2_i;
      OP_NOR:  w_logic = ~(reg1_i | reg2_i);
      OP_SLL:  w_shres = reg2_i << reg1_i[4:0];
      OP_SRL:  w_shres = reg2_i >> reg1_i[4:0];
      OP_SRA:  w_shres = $signed(reg2_i) >>> reg1_i[4:0];
      OP_ADDU: w_arith = reg1_i + reg2_i;
      OP_SUBU: w_arith = reg1_i - reg2_i;
      OP_SLT:  w_arith = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
      OP_SLTU: w_arith = {31'd0, (reg1_i < reg2_i)};
      default: ;
    endcase
    case (alusel_i)
      SEL_LOGIC: w_sel = w_logic;
      SEL_SHIFT: w_sel = w_shres;
      SEL_ARITH: w_sel = w_arith;
      default:   w_sel = 32'd0;
    endcase
  end

  assign wdata_o = rst ? w_sel  : 32'd0;
  assign wd_o    = rst ? wd_i   : 5'd0;
  assign wreg_o  = rst ? wreg_i : 1'b0;

endmodule

`default_nettype wire
